// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx - PS/2 keyboard receiver for the Vector-06C keyboard path.
//
// Deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop)
// arriving from the IO block. E0/F0 prefix bytes are folded into the
// following scancode so each key event is delivered as a single
// {code, ext, rel} record.
//
// Optional build macro: PS2_RX_FIFO_EN
//   undefined : key_valid is a one-cycle pulse; key_code/key_ext/key_rel hold
//               their last value; key_ack is ignored.
//   defined   : events are queued in a 2**FIFO_DEPTH_LOG2-entry first-word
//               fall-through FIFO; key_valid = not empty, key_ack pops.
//
// Ports:
//   clk_sys       in   system clock
//   reset         in   synchronous active-high reset
//   ps2_kbd_clk   in   PS/2 clock (idles high), asynchronous to clk_sys
//   ps2_kbd_data  in   PS/2 data, asynchronous to clk_sys
//   key_valid     out  event available
//   key_code      out  scancode without prefixes
//   key_ext       out  event was preceded by E0
//   key_rel       out  event was preceded by F0
//   key_ack       in   pop one event (FIFO build only)
//   frame_err     out  one-cycle pulse on start/parity/stop/timeout error
//                      or on an event dropped by a full FIFO
module ps2_kbd_rx #(
  parameter int TIMEOUT         = 1000,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_rel,
  input  logic       key_ack,
  output logic       frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t           state_q, state_d;
  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d, par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             byte_vld_q, byte_vld_d, err_q, err_d;
  logic             ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic             frame_err_q, frame_err_d;
  logic             fall, timeout, evt, drop;

  // Synchronisers and frame FSM
  always_comb begin
    clk_s1_d   = ps2_kbd_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_kbd_data;
    dat_s2_d   = dat_s1_q;
    fall       = clk_prev_q & ~clk_s2_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    par_ok_d   = par_ok_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;

    if (fall || state_q == ST_IDLE) tmo_d = '0;
    else                            tmo_d = tmo_q + TMO_W'(1);
    timeout = (state_q != ST_IDLE) && !fall && (tmo_q == TMO_W'(TIMEOUT - 1));

    case (state_q)
      ST_IDLE: if (fall) begin
        if (!dat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_DATA: if (fall) begin
        shreg_d   = {dat_s2_q, shreg_q[7:1]};
        par_d     = par_q ^ dat_s2_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
      end
      ST_PARITY: if (fall) begin
        par_ok_d = par_q ^ dat_s2_q;
        state_d  = ST_STOP;
      end
      ST_STOP: if (fall) begin
        if (dat_s2_q && par_ok_q) byte_vld_d = 1'b1;
        else                      err_d      = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // Prefix folding; an error (including timeout) discards pending prefixes
  always_comb begin
    evt        = byte_vld_q && (shreg_q != CODE_E0) && (shreg_q != CODE_F0);
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    if (err_q) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shreg_q == CODE_E0)      ext_pend_d = 1'b1;
      else if (shreg_q == CODE_F0) rel_pend_d = 1'b1;
      else begin
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end
    end
    frame_err_d = err_q | drop;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      byte_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_prev_q  <= clk_prev_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      byte_vld_q  <= byte_vld_d;
      err_q       <= err_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

`ifdef PS2_RX_FIFO_EN
  // Event FIFO, first-word fall-through
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [9:0]               fifo_mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     empty, full, push, pop;
  logic [9:0]               head;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[FIFO_DEPTH_LOG2] != rd_ptr_q[FIFO_DEPTH_LOG2]) &&
               (wr_ptr_q[FIFO_DEPTH_LOG2-1:0] == rd_ptr_q[FIFO_DEPTH_LOG2-1:0]);
    pop      = key_ack && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    push     = evt && (!full || pop);
    drop     = evt && full && !pop;
    wr_ptr_d = wr_ptr_q + {{FIFO_DEPTH_LOG2{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{FIFO_DEPTH_LOG2{1'b0}}, pop};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= {ext_pend_q, rel_pend_q, shreg_q};
  end

  assign head = fifo_mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];

  // Outputs read zero while empty so stale storage never shows after reset
  assign key_valid = !empty;
  assign key_ext   = !empty && head[9];
  assign key_rel   = !empty && head[8];
  assign key_code  = empty ? 8'h00 : head[7:0];
`else
  // Event output register
  localparam int unused_fifo_log2 = FIFO_DEPTH_LOG2;

  logic       ack_unused;
  logic       key_valid_q, key_valid_d, key_ext_q, key_ext_d, key_rel_q, key_rel_d;
  logic [7:0] key_code_q, key_code_d;

  assign ack_unused = key_ack;
  assign drop       = 1'b0;

  always_comb begin
    key_valid_d = evt;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    if (evt) begin
      key_code_d = shreg_q;
      key_ext_d  = ext_pend_q;
      key_rel_d  = rel_pend_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_rel   = key_rel_q;
`endif

endmodule
